// File: rtl/xup_shift_seq_pkg.sv
// Shared types and limits for the shift-register sequencer.
// Used by xup_shift_sequencer and its tick generator.
package xup_shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DIVIDE_MAX = 65535;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xup_shift_sequencer_if.sv
// Word handshake and shift-register control bundle for xup_shift_sequencer.
// The master is the word producer; the slave is the sequencer.
interface xup_shift_sequencer_if #(
  parameter int unsigned SIZE = 4
);
  logic            start_valid;
  logic            start_ready;
  logic [SIZE-1:0] start_data;
  logic            start_dir;
  logic            abort;
  logic            busy;
  logic            done;
  logic            sr_load;
  logic            sr_en;
  logic            sr_dir;
  logic [SIZE-1:0] sr_parallel_in;

  modport master (
    output start_valid, start_data, start_dir, abort,
    input  start_ready, busy, done, sr_load, sr_en, sr_dir, sr_parallel_in
  );

  modport slave (
    input  start_valid, start_data, start_dir, abort,
    output start_ready, busy, done, sr_load, sr_en, sr_dir, sr_parallel_in
  );
endinterface

// File: rtl/xup_shift_tick_gen.sv
// Shift-rate prescaler: while run is high, tick pulses once every DIVIDE cycles.
// clear restarts the count so the first tick lands DIVIDE cycles after run begins.
module xup_shift_tick_gen
  import xup_shift_seq_pkg::*;
#(
  parameter int unsigned DIVIDE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int unsigned W = cnt_width(DIVIDE);
  localparam logic [W-1:0] LAST = W'(DIVIDE - 1);

  logic [W-1:0] r_presc;
  logic         w_at_last;

  assign w_at_last = (r_presc == LAST);
  assign tick      = run && w_at_last;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_presc <= '0;
    end else if (run) begin
      r_presc <= w_at_last ? '0 : r_presc + W'(1);
    end
  end
endmodule

// File: rtl/xup_shift_sequencer.sv
// Loads one word into an external shift register and issues SIZE shift enables.
// Optional capture of the shifted-in word: define XUP_SHIFT_SEQ_CAPTURE_EN.
module xup_shift_sequencer
  import xup_shift_seq_pkg::*;
#(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned DIVIDE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  xup_shift_sequencer_if.slave  bus
`ifdef XUP_SHIFT_SEQ_CAPTURE_EN
  ,
  input  logic [SIZE-1:0]       sr_parallel_out,
  output logic [SIZE-1:0]       rx_data
`endif
);
  localparam int unsigned CW = $clog2(SIZE + 1);

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_data;
  logic            r_dir;
  logic [CW-1:0]   r_bits;
  logic            w_tick;
  logic            w_last_bit;
  logic            w_handshake;
  logic            w_load;
  logic            w_en;
  logic            w_done;
  logic            w_busy;

  assign w_handshake = bus.start_valid && (r_state == IDLE);
  assign w_last_bit  = (r_bits == CW'(SIZE - 1));

  xup_shift_tick_gen #(
    .DIVIDE (DIVIDE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (r_state == LOAD),
    .run   (r_state == SHIFT),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_en   = 1'b0;
    w_done = 1'b0;
    w_busy = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start_valid) w_next = LOAD;
      end
      LOAD: begin
        w_load = 1'b1;
        w_next = SHIFT;
      end
      SHIFT: begin
        w_en = w_tick;
        if (w_tick && w_last_bit) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Abort only cancels work in flight; a word offered in IDLE is still taken.
    if (bus.abort && (r_state != IDLE)) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_dir  <= 1'b0;
    end else if (w_handshake) begin
      r_data <= bus.start_data;
      r_dir  <= bus.start_dir;
    end
  end

  // Bit counter stops at SIZE because SHIFT is left on the SIZE-th tick.
  always_ff @(posedge clk) begin
    if (reset || (r_state == LOAD)) begin
      r_bits <= '0;
    end else if ((r_state == SHIFT) && w_tick) begin
      r_bits <= r_bits + CW'(1);
    end
  end

`ifdef XUP_SHIFT_SEQ_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data <= '0;
    end else if ((r_state == DONE) && !bus.abort) begin
      rx_data <= sr_parallel_out;
    end
  end
`endif

  assign bus.start_ready    = (r_state == IDLE);
  assign bus.busy           = w_busy;
  assign bus.done           = w_done;
  assign bus.sr_load        = w_load;
  assign bus.sr_en          = w_en;
  assign bus.sr_dir         = r_dir;
  assign bus.sr_parallel_in = r_data;
endmodule

// File: doc/xup_shift_sequencer.md
# xup_shift_sequencer

Sequencing controller for the team's parameterised shift-register datapath. It accepts one parallel word per valid/ready transaction, loads it into the external shift register, and issues exactly SIZE shift enables in the requested direction at a programmable rate. It then pulses `done` and returns to idle. It sits between a word-level producer (UART-style transmitter, LED scanner, lab FSM) and the shift register's `load`/`en`/`dir`/`parallel_in` pins.

## Interface
- `SIZE`, 4: width of the controlled shift register and of `start_data`; legal values are 2 to 32.
- `DIVIDE`, 1: clock cycles per shift; legal values are 1 to 65535.
- `clk` in 1: rising-edge clock, the only clock in the block.
- `reset` in 1: synchronous, active-high reset.
- `start_valid` in 1: the producer has a word ready.
- `start_ready` out 1: the sequencer accepts a word; high only in IDLE.
- `start_data` in SIZE: word to load.
- `start_dir` in 1: shift direction; 1 = left (MSB out), 0 = right (LSB out).
- `abort` in 1: cancels the transaction in progress.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a transaction completes normally.
- `sr_load` out 1: drives the shift register's `load`.
- `sr_en` out 1: drives the shift register's `en`.
- `sr_dir` out 1: drives the shift register's `dir`.
- `sr_parallel_in` out SIZE: drives the shift register's `parallel_in`.
- `sr_parallel_out` in SIZE: the shift register's `parallel_out`; present only with the capture feature.
- `rx_data` out SIZE: captured word; present only with the capture feature.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- **IDLE:**
  - `start_ready` = 1.
  - A handshake occurs when `start_valid` and `start_ready` are both high.
  - On a handshake, latch `start_data` into `data_q` and `start_dir` into `dir_q`, then go to LOAD.
- **LOAD:** `sr_load` = 1 for exactly one cycle, then go to SHIFT. The bit counter and the prescaler both clear to 0.
- **SHIFT:**
  - The prescaler counts 0..DIVIDE-1 and wraps.
  - `tick` = (prescaler == DIVIDE-1).
  - `sr_en` = `tick`.
  - The bit counter increments on each `tick`.
  - After the SIZE-th `tick`, go to DONE.
  - The counter is $clog2(SIZE+1) bits wide and never wraps.
- **DONE:** `done` = 1 for one cycle, then go to IDLE.
- `sr_dir` = `dir_q` and `sr_parallel_in` = `data_q` at all times. Both are stable for the whole transaction.
- All outputs are Moore outputs decoded from registered state, except `start_ready`, which is (state == IDLE).
- **Abort:**
  - `abort` high in LOAD, SHIFT or DONE forces IDLE on the next edge.
  - No `done` pulse is produced and no further `sr_en` is issued after that edge.
  - `abort` in IDLE is ignored.
  - If `abort` and `start_valid` are both high in IDLE, the word is accepted.
- **Reset:**
  - State goes to IDLE; `data_q`, `dir_q`, both counters and `rx_data` clear to 0.
  - Reset values: `sr_load`, `sr_en`, `done`, `busy` = 0; `start_ready` = 1; `sr_dir` = 0; `sr_parallel_in` = 0.
  - Reset asserted mid-transaction behaves like `abort` and has priority over it.
- `start_valid` held high through DONE is not accepted until the IDLE cycle. This gives one idle bubble per word.

## Timing
- Handshake at cycle T.
- `sr_load` is high at T+1.
- `sr_en` is high at T+1+k·DIVIDE for k = 1..SIZE.
- `done` is high at T+2+SIZE·DIVIDE.
- The next handshake is possible at T+3+SIZE·DIVIDE.
- With DIVIDE = 1, `sr_en` is contiguous over T+2..T+1+SIZE.
- `busy` is high from T+1 through the DONE cycle inclusive.

## Configuration
- Macro: `XUP_SHIFT_SEQ_CAPTURE_EN`.
- **Defined:**
  - The `sr_parallel_out` and `rx_data` ports exist.
  - In the DONE cycle, `rx_data` <= `sr_parallel_out`, i.e. the SIZE bits serially shifted in.
  - `rx_data` holds that value until the next DONE or reset; abort leaves it unchanged.
- **Undefined:** both ports are absent and there is no capture register. All other behaviour is identical.

## Structure
- Package `xup_shift_seq_pkg` holds:
  - the state enum (IDLE = 0, LOAD = 1, SHIFT = 2, DONE = 3), 2 bits;
  - the constant DIVIDE_MAX = 65535.
- Sub-module `xup_shift_tick_gen` (parameter DIVIDE):
  - inputs `clk`, `reset`, `clear`, `run`; output `tick`;
  - owns the prescaler counter.
- The shift register itself is instantiated by the parent or bench, not inside this block.

## Test plan
- SIZE = 4, DIVIDE = 1; handshake `start_data` = 4'b1011, `start_dir` = 1 at T -> `sr_load` at T+1; `sr_en` at T+2..T+5; `done` at T+6; `start_ready` back to 1 at T+7.
- SIZE = 4, DIVIDE = 3, `start_dir` = 0 -> `sr_en` only at T+4, T+7, T+10, T+13; `done` at T+14; `sr_dir` = 0 throughout.
- Capture on; shift register attached; `shift_in` driven 1,0,0,1 on the four shifts, `dir` = 1 -> `rx_data` = 4'b1001 one cycle after `done`.
- `abort` at T+3 with DIVIDE = 1 -> IDLE at T+4; no `sr_en` from T+4 on; no `done`; `start_ready` = 1 at T+4.
- `reset` at T+2, same cycle as `abort` -> all outputs at reset values at T+3; a new handshake at T+3 is accepted.
- `start_valid` held high continuously for back-to-back words -> handshakes exactly 3+SIZE·DIVIDE cycles apart; each `done` is one cycle wide.
